// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: single-outstanding fetch FSM feeding a
// small PC-tagged instruction FIFO, flushed and restarted on redirect.
module inst_fetch_queue #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          discard_q, discard_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   data_q [QUEUE_DEPTH];
    logic [31:0]   data_d [QUEUE_DEPTH];
    logic [31:0]   pc_q [QUEUE_DEPTH];
    logic [31:0]   pc_d [QUEUE_DEPTH];

    logic          push;
    logic          pop;
    logic [CW-1:0] count_after_push;

    assign mem_req    = (state_q == REQ);
    assign mem_addr   = req_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst       = data_q[rd_ptr_q];
    assign inst_pc    = pc_q[rd_ptr_q];

    assign pop              = inst_valid & inst_ready;
    assign count_after_push = count_q + CW'(1) - CW'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        push       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (count_q < FULL && !redirect) begin
                    state_d  = REQ;
                    req_pc_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (discard_q || redirect) begin
                        state_d = DRAIN;
                    end else begin
                        state_d    = RESP;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            RESP: begin
                // A redirect squashes the in-flight response, even one landing now
                if (redirect) begin
                    state_d = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
                    push = 1'b1;
                    if (count_after_push < FULL) begin
                        state_d  = REQ;
                        req_pc_d = fetch_pc_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (mem_rvalid) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end
            end
        endcase

        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'h3;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        pc_d     = pc_q;

        if (push) begin
            data_d[wr_ptr_q] = mem_rdata;
            pc_d[wr_ptr_q]   = req_pc_q;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            discard_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
        end
    end

endmodule
